// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 3-sample majority vote, parity/framing/overrun flags, DV/ack handshake.
// Optional break detection is compiled in with `define UART_RX_BREAK_DETECT_EN (adds o_Rx_Break).
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 2,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Rx_Ack,
  output logic                 o_Rx_Active,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Rx_Parity_Err,
  output logic                 o_Rx_Frame_Err,
  output logic                 o_Rx_Overrun
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                 o_Rx_Break
`endif
);

  localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int MID = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_MID_M1 = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_MID    = CW'(MID);
  localparam logic [CW-1:0] CNT_MID_P1 = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT   = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP  = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [1:0]           sync_reg;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [3:0]           bit_idx_reg, bit_idx_next;
  logic                 stop_idx_reg, stop_idx_next;
  logic [1:0]           samp_reg, samp_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_acc_reg, par_acc_next;
  logic                 par_pend_reg, par_pend_next;
  logic                 frm_pend_reg, frm_pend_next;
  logic                 active_reg, active_next;
  logic                 dv_reg, dv_next;
  logic [DATA_BITS-1:0] byte_reg, byte_next;
  logic                 perr_reg, perr_next;
  logic                 ferr_reg, ferr_next;
  logic                 ovr_reg, ovr_next;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                 stop_zero_reg, stop_zero_next;
  logic                 break_reg, break_next;
  logic                 brk_wait_reg, brk_wait_next;
`endif

  logic          rx_s;
  logic          vote;
  logic          exp_par;
  logic          at_mid_m1, at_mid, at_mid_p1, at_end;
  logic [CW-1:0] cnt_tick;

  assign rx_s      = sync_reg[1];
  assign at_mid_m1 = (cnt_reg == CNT_MID_M1);
  assign at_mid    = (cnt_reg == CNT_MID);
  assign at_mid_p1 = (cnt_reg == CNT_MID_P1);
  assign at_end    = (cnt_reg == CNT_LAST);
  assign cnt_tick  = at_end ? '0 : cnt_reg + CW'(1);
  // The third sample is the live rx_s at MID+1, so the vote is ready in that same cycle.
  assign vote      = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);
  assign exp_par   = (PARITY_MODE == 1) ? ~par_acc_reg : par_acc_reg;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], i_Rx_Serial};
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      stop_idx_reg  <= 1'b0;
      samp_reg      <= '0;
      shift_reg     <= '0;
      par_acc_reg   <= 1'b0;
      par_pend_reg  <= 1'b0;
      frm_pend_reg  <= 1'b0;
      active_reg    <= 1'b0;
      dv_reg        <= 1'b0;
      byte_reg      <= '0;
      perr_reg      <= 1'b0;
      ferr_reg      <= 1'b0;
      ovr_reg       <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      stop_zero_reg <= 1'b0;
      break_reg     <= 1'b0;
      brk_wait_reg  <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      stop_idx_reg  <= stop_idx_next;
      samp_reg      <= samp_next;
      shift_reg     <= shift_next;
      par_acc_reg   <= par_acc_next;
      par_pend_reg  <= par_pend_next;
      frm_pend_reg  <= frm_pend_next;
      active_reg    <= active_next;
      dv_reg        <= dv_next;
      byte_reg      <= byte_next;
      perr_reg      <= perr_next;
      ferr_reg      <= ferr_next;
      ovr_reg       <= ovr_next;
`ifdef UART_RX_BREAK_DETECT_EN
      stop_zero_reg <= stop_zero_next;
      break_reg     <= break_next;
      brk_wait_reg  <= brk_wait_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    stop_idx_next  = stop_idx_reg;
    samp_next      = samp_reg;
    shift_next     = shift_reg;
    par_acc_next   = par_acc_reg;
    par_pend_next  = par_pend_reg;
    frm_pend_next  = frm_pend_reg;
    active_next    = active_reg;
    dv_next        = dv_reg;
    byte_next      = byte_reg;
    perr_next      = perr_reg;
    ferr_next      = ferr_reg;
    ovr_next       = ovr_reg;
`ifdef UART_RX_BREAK_DETECT_EN
    stop_zero_next = stop_zero_reg;
    break_next     = break_reg;
    brk_wait_next  = brk_wait_reg;
`endif

    if (at_mid_m1) samp_next[0] = rx_s;
    if (at_mid)    samp_next[1] = rx_s;

    if (i_Rx_Ack && dv_reg) begin
      dv_next    = 1'b0;
      ovr_next   = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      break_next = 1'b0;
`endif
    end

    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
`ifdef UART_RX_BREAK_DETECT_EN
        // After a break the line must show a full bit time of idle before a new start counts.
        if (brk_wait_reg) begin
          if (rx_s) begin
            if (at_end) brk_wait_next = 1'b0;
            else        cnt_next = cnt_reg + CW'(1);
          end
        end else
`endif
        if (!rx_s) begin
          state_next     = S_START;
          shift_next     = '0;
          par_acc_next   = 1'b0;
          par_pend_next  = 1'b0;
          frm_pend_next  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
          stop_zero_next = 1'b1;
`endif
        end
      end

      S_START: begin
        cnt_next = cnt_tick;
        if (at_mid_p1 && vote) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          if (at_mid_p1) active_next = 1'b1;
          if (at_end) begin
            state_next   = S_DATA;
            bit_idx_next = '0;
          end
        end
      end

      S_DATA: begin
        cnt_next = cnt_tick;
        if (at_mid_p1) begin
          shift_next   = {vote, shift_reg[DATA_BITS-1:1]};
          par_acc_next = par_acc_reg ^ vote;
        end
        if (at_end) begin
          if (bit_idx_reg == LAST_BIT) begin
            bit_idx_next  = '0;
            stop_idx_next = 1'b0;
            state_next    = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 4'd1;
          end
        end
      end

      S_PARITY: begin
        cnt_next = cnt_tick;
        if (at_mid_p1 && (vote != exp_par)) par_pend_next = 1'b1;
        if (at_end) begin
          state_next    = S_STOP;
          stop_idx_next = 1'b0;
        end
      end

      S_STOP: begin
        cnt_next = cnt_tick;
        if (at_mid_p1) begin
          if (!vote) frm_pend_next = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
          if (vote)  stop_zero_next = 1'b0;
`endif
        end
        // Leaving mid-way through the last stop bit lets the next start edge resynchronise us.
        if (at_mid_p1 && (stop_idx_reg == LAST_STOP)) begin
          state_next = S_DONE;
          cnt_next   = '0;
        end else if (at_end) begin
          stop_idx_next = stop_idx_reg + 1'b1;
        end
      end

      S_DONE: begin
        byte_next   = shift_reg;
        perr_next   = (PARITY_MODE != 0) ? par_pend_reg : 1'b0;
        ferr_next   = frm_pend_reg;
        dv_next     = 1'b1;
        active_next = 1'b0;
        ovr_next    = dv_reg & ~i_Rx_Ack;
`ifdef UART_RX_BREAK_DETECT_EN
        break_next    = (shift_reg == '0) && stop_zero_reg;
        brk_wait_next = (shift_reg == '0) && stop_zero_reg;
`endif
        state_next  = S_IDLE;
        cnt_next    = '0;
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign o_Rx_Active     = active_reg;
  assign o_Rx_DV         = dv_reg;
  assign o_Rx_Byte       = byte_reg;
  assign o_Rx_Parity_Err = perr_reg;
  assign o_Rx_Frame_Err  = ferr_reg;
  assign o_Rx_Overrun    = ovr_reg;
`ifdef UART_RX_BREAK_DETECT_EN
  assign o_Rx_Break      = break_reg;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (defaults, odd parity, 9-bit/2-stop).
// Expected words are queued when a frame is driven and compared when the DUT completes it.
module tb_uart_rx_cfg;
  localparam int CPB = 16;

  typedef struct packed {
    logic       dv;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b0, rst1 = 1'b0, rst2 = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic ack0 = 1'b0, ack1 = 1'b0, ack2 = 1'b0;
  logic act0, dv0, perr0, ferr0, ovr0;
  logic act1, dv1, perr1, ferr1, ovr1;
  logic act2, dv2, perr2, ferr2, ovr2;
  logic [7:0] byte0, byte1;
  logic [8:0] byte2;
`ifdef UART_RX_BREAK_DETECT_EN
  logic brk0, brk1, brk2;
`endif

  uart_rx_cfg #(.CLKS_PER_BIT(CPB)) dut0 (
    .i_Clock(clk), .i_Reset(rst0), .i_Rx_Serial(rx0), .i_Rx_Ack(ack0),
    .o_Rx_Active(act0), .o_Rx_DV(dv0), .o_Rx_Byte(byte0),
    .o_Rx_Parity_Err(perr0), .o_Rx_Frame_Err(ferr0), .o_Rx_Overrun(ovr0)
`ifdef UART_RX_BREAK_DETECT_EN
    , .o_Rx_Break(brk0)
`endif
  );

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .PARITY_MODE(1)) dut1 (
    .i_Clock(clk), .i_Reset(rst1), .i_Rx_Serial(rx1), .i_Rx_Ack(ack1),
    .o_Rx_Active(act1), .o_Rx_DV(dv1), .o_Rx_Byte(byte1),
    .o_Rx_Parity_Err(perr1), .o_Rx_Frame_Err(ferr1), .o_Rx_Overrun(ovr1)
`ifdef UART_RX_BREAK_DETECT_EN
    , .o_Rx_Break(brk1)
`endif
  );

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .STOP_BITS(2)) dut2 (
    .i_Clock(clk), .i_Reset(rst2), .i_Rx_Serial(rx2), .i_Rx_Ack(ack2),
    .o_Rx_Active(act2), .o_Rx_DV(dv2), .o_Rx_Byte(byte2),
    .o_Rx_Parity_Err(perr2), .o_Rx_Frame_Err(ferr2), .o_Rx_Overrun(ovr2)
`ifdef UART_RX_BREAK_DETECT_EN
    , .o_Rx_Break(brk2)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;
  rec_t exp_q0[$], exp_q1[$], exp_q2[$];
  rec_t obs_q0[$], obs_q1[$], obs_q2[$];
  bit mdl_dv [3];
  int act_cnt0 = 0;

  // A word is complete on the edge where Active falls outside reset; capture outputs then.
  logic act_prev0 = 1'b0, act_prev1 = 1'b0, act_prev2 = 1'b0;
  always @(negedge clk) begin
    if (!rst0 && act_prev0 && !act0) obs_q0.push_back({dv0, 1'b0, byte0, perr0, ferr0, ovr0});
    if (act0) act_cnt0 <= act_cnt0 + 1;
    act_prev0 <= act0;
  end
  always @(negedge clk) begin
    if (!rst1 && act_prev1 && !act1) obs_q1.push_back({dv1, 1'b0, byte1, perr1, ferr1, ovr1});
    act_prev1 <= act1;
  end
  always @(negedge clk) begin
    if (!rst2 && act_prev2 && !act2) obs_q2.push_back({dv2, byte2, perr2, ferr2, ovr2});
    act_prev2 <= act2;
  end

  function automatic rec_t model_word(input int nbits, input int mode, input logic [8:0] data,
                                      input logic pbit, input logic [1:0] stop_pat,
                                      input int nstops, input bit prev_dv);
    rec_t r;
    logic [8:0] m;
    logic x;
    m = data & ((9'h1 << nbits) - 9'h1);
    x = ^m;
    r.dv   = 1'b1;
    r.data = m;
    r.perr = (mode == 0) ? 1'b0 : ((mode == 1) ? (pbit != ~x) : (pbit != x));
    r.ferr = (nstops == 2) ? ~(stop_pat[0] & stop_pat[1]) : ~stop_pat[0];
    r.ovr  = prev_dv;
    return r;
  endfunction

  task automatic set_line(input int d, input logic v);
    case (d)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic hold(input int d, input logic v, input int n);
    set_line(d, v);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int d, input int nbits, input int mode, input int nstops,
                            input logic [8:0] data, input logic pbit, input logic [1:0] stop_pat,
                            input int gbit, input int goff);
    logic [15:0] fb;
    int n;
    fb = '0;
    n = 1;
    for (int i = 0; i < nbits; i++) begin fb[n] = data[i]; n++; end
    if (mode != 0) begin fb[n] = pbit; n++; end
    for (int i = 0; i < nstops; i++) begin fb[n] = stop_pat[i]; n++; end
    for (int k = 0; k < n; k++) begin
      if (k == gbit) begin
        hold(d, fb[k], goff);
        hold(d, ~fb[k], 1);
        hold(d, fb[k], CPB - goff - 1);
      end else begin
        hold(d, fb[k], CPB);
      end
    end
  endtask

  task automatic push_exp(input int d, input rec_t e);
    case (d)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
    mdl_dv[d] = 1'b1;
  endtask

  task automatic pop_exp(input int d, output rec_t e);
    e = '0;
    case (d)
      0: if (exp_q0.size() > 0) e = exp_q0.pop_front();
      1: if (exp_q1.size() > 0) e = exp_q1.pop_front();
      default: if (exp_q2.size() > 0) e = exp_q2.pop_front();
    endcase
  endtask

  task automatic wait_obs(input int d, output rec_t r, output bit ok);
    ok = 1'b0;
    r = '0;
    for (int i = 0; i < 400 && !ok; i++) begin
      case (d)
        0: if (obs_q0.size() > 0) begin r = obs_q0.pop_front(); ok = 1'b1; end
        1: if (obs_q1.size() > 0) begin r = obs_q1.pop_front(); ok = 1'b1; end
        default: if (obs_q2.size() > 0) begin r = obs_q2.pop_front(); ok = 1'b1; end
      endcase
      if (!ok) @(negedge clk);
    end
  endtask

  task automatic do_ack(input int d);
    case (d)
      0: ack0 = 1'b1;
      1: ack1 = 1'b1;
      default: ack2 = 1'b1;
    endcase
    @(negedge clk);
    ack0 = 1'b0; ack1 = 1'b0; ack2 = 1'b0;
    mdl_dv[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({act0, dv0, byte0, perr0, ferr0, ovr0} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_dut0: outputs %b, required all 0", {act0, dv0, byte0, perr0, ferr0, ovr0});
    end
    tests_run++;
    if ({act1, dv1, byte1, perr1, ferr1, ovr1} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_dut1: outputs %b, required all 0", {act1, dv1, byte1, perr1, ferr1, ovr1});
    end
    tests_run++;
    if ({act2, dv2, byte2, perr2, ferr2, ovr2} !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_dut2: outputs %b, required all 0", {act2, dv2, byte2, perr2, ferr2, ovr2});
    end
`ifdef UART_RX_BREAK_DETECT_EN
    tests_run++;
    if ({brk0, brk1, brk2} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_break: got %b required 000", {brk0, brk1, brk2});
    end
`endif
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    mdl_dv[0] = 1'b0; mdl_dv[1] = 1'b0; mdl_dv[2] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    rec_t e, o;
    bit ok;
    push_exp(0, model_word(8, 2, 9'h0A5, 1'b0, 2'b11, 1, mdl_dv[0]));
    send_frame(0, 8, 2, 1, 9'h0A5, 1'b0, 2'b11, -1, 0);
    wait_obs(0, o, ok);
    pop_exp(0, e);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL basic_word: no word within budget, required data=%h", e.data);
    end else if (o !== e) begin
      tests_failed++;
      $display("FAIL basic_word: got dv=%b data=%h perr=%b ferr=%b ovr=%b, required dv=%b data=%h perr=%b ferr=%b ovr=%b",
               o.dv, o.data, o.perr, o.ferr, o.ovr, e.dv, e.data, e.perr, e.ferr, e.ovr);
    end
    do_ack(0);
    tests_run++;
    if ({dv0, ovr0} !== 2'b00) begin
      tests_failed++;
      $display("FAIL basic_ack: got dv=%b ovr=%b, required 0 0", dv0, ovr0);
    end
  endtask

  task automatic test_odd_parity();
    rec_t e, o;
    bit ok;
    logic pb;
    for (int i = 0; i < 2; i++) begin
      pb = (i == 0) ? 1'b1 : 1'b0;
      push_exp(1, model_word(8, 1, 9'h03C, pb, 2'b11, 1, mdl_dv[1]));
      send_frame(1, 8, 1, 1, 9'h03C, pb, 2'b11, -1, 0);
      wait_obs(1, o, ok);
      pop_exp(1, e);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL odd_parity_%0d: no word within budget, required data=%h", i, e.data);
      end else if (o !== e) begin
        tests_failed++;
        $display("FAIL odd_parity_%0d: got dv=%b data=%h perr=%b ferr=%b ovr=%b, required dv=%b data=%h perr=%b ferr=%b ovr=%b",
                 i, o.dv, o.data, o.perr, o.ferr, o.ovr, e.dv, e.data, e.perr, e.ferr, e.ovr);
      end
      do_ack(1);
    end
  endtask

  task automatic test_false_start();
    int act_before;
    act_before = act_cnt0;
    hold(0, 1'b0, 3);
    hold(0, 1'b1, 60);
    tests_run++;
    if (obs_q0.size() != 0) begin
      tests_failed++;
      $display("FAIL false_start_word: got %0d words, required 0", obs_q0.size());
    end
    tests_run++;
    if (act_cnt0 != act_before) begin
      tests_failed++;
      $display("FAIL false_start_active: active for %0d cycles, required 0", act_cnt0 - act_before);
    end
    tests_run++;
    if (dv0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL false_start_dv: got %b required 0", dv0);
    end
  endtask

  task automatic test_glitch();
    rec_t e, o;
    bit ok;
    push_exp(0, model_word(8, 2, 9'h0FF, 1'b0, 2'b11, 1, mdl_dv[0]));
    // Frame bit 3 is data bit 2; offset 9 lands on the middle sample.
    send_frame(0, 8, 2, 1, 9'h0FF, 1'b0, 2'b11, 3, 9);
    wait_obs(0, o, ok);
    pop_exp(0, e);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL glitch_word: no word within budget, required data=%h", e.data);
    end else if (o !== e) begin
      tests_failed++;
      $display("FAIL glitch_word: got dv=%b data=%h perr=%b ferr=%b ovr=%b, required dv=%b data=%h perr=%b ferr=%b ovr=%b",
               o.dv, o.data, o.perr, o.ferr, o.ovr, e.dv, e.data, e.perr, e.ferr, e.ovr);
    end
    do_ack(0);
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    bit ok;
    logic [8:0] w;
    for (int i = 0; i < 2; i++) begin
      w = (i == 0) ? 9'h011 : 9'h022;
      push_exp(0, model_word(8, 2, w, ^w, 2'b11, 1, mdl_dv[0]));
      send_frame(0, 8, 2, 1, w, ^w, 2'b11, -1, 0);
    end
    for (int i = 0; i < 2; i++) begin
      wait_obs(0, o, ok);
      pop_exp(0, e);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL b2b_word_%0d: no word within budget, required data=%h", i, e.data);
      end else if (o !== e) begin
        tests_failed++;
        $display("FAIL b2b_word_%0d: got dv=%b data=%h perr=%b ferr=%b ovr=%b, required dv=%b data=%h perr=%b ferr=%b ovr=%b",
                 i, o.dv, o.data, o.perr, o.ferr, o.ovr, e.dv, e.data, e.perr, e.ferr, e.ovr);
      end
    end
    do_ack(0);
    tests_run++;
    if ({dv0, ovr0} !== 2'b00) begin
      tests_failed++;
      $display("FAIL b2b_ack: got dv=%b ovr=%b, required 0 0", dv0, ovr0);
    end
  endtask

  task automatic test_wide_frame();
    rec_t e, o;
    bit ok;
    push_exp(2, model_word(9, 2, 9'h1AB, ^9'h1AB, 2'b01, 2, mdl_dv[2]));
    send_frame(2, 9, 2, 2, 9'h1AB, ^9'h1AB, 2'b01, -1, 0);
    hold(2, 1'b1, 3 * CPB);
    wait_obs(2, o, ok);
    pop_exp(2, e);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL wide_word: no word within budget, required data=%h", e.data);
    end else if (o !== e) begin
      tests_failed++;
      $display("FAIL wide_word: got dv=%b data=%h perr=%b ferr=%b ovr=%b, required dv=%b data=%h perr=%b ferr=%b ovr=%b",
               o.dv, o.data, o.perr, o.ferr, o.ovr, e.dv, e.data, e.perr, e.ferr, e.ovr);
    end
    tests_run++;
    if (obs_q2.size() != 0) begin
      tests_failed++;
      $display("FAIL wide_extra_word: got %0d extra words, required 0", obs_q2.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    hold(2, 1'b0, CPB);
    hold(2, 1'b1, CPB);
    hold(2, 1'b1, CPB);
    hold(2, 1'b0, CPB / 2);
    rst2 = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({act2, dv2, byte2, perr2, ferr2, ovr2} !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got %b, required all 0", {act2, dv2, byte2, perr2, ferr2, ovr2});
    end
    rx2 = 1'b1;
    rst2 = 1'b0;
    mdl_dv[2] = 1'b0;
    repeat (14 * CPB) @(negedge clk);
    tests_run++;
    if (obs_q2.size() != 0 || dv2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_dv: got %0d words dv=%b, required 0 words dv=0", obs_q2.size(), dv2);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_odd_parity();
    test_false_start();
    test_glitch();
    test_back_to_back();
    test_wide_frame();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
